sa_wb_collector: RTL
====================

SA_WB_COLLECTOR -- requirements
Module: sa_wb_collector

Interface
REQ-001 Parameters SHALL be: DEPTH, default 16, FIFO entries (power of 2); BIT_ADDR, default 16, memory word-address width.
REQ-002 Data width SHALL be `BIT_PSUM from the shared parameter file; the FIFO pointer width SHALL be log2(DEPTH).
REQ-003 There SHALL be one clock, CLK; reset SHALL be RSTb, asynchronous, active-low.
REQ-004 Ports SHALL be:
- CLK  in  1  clock
- RSTb  in  1  async active-low reset
- i_Start  in  1  one-cycle pulse; begin a collection job
- i_Base_Addr  in  BIT_ADDR  first destination word address, sampled on i_Start
- i_Valid_WB_In  in  1  psum write-back strobe from systolic core
- i_Data_WB_In  in  `BIT_PSUM  psum write-back data
- i_Flag_Finish_In  in  1  core finished producing results
- o_Mem_Valid  out  1  memory write request
- o_Mem_Addr  out  BIT_ADDR  memory write address
- o_Mem_Data  out  `BIT_PSUM  memory write data
- i_Mem_Ready  in  1  memory accepts request
- o_Done  out  1  one-cycle pulse; job fully written
- o_Overflow  out  1  sticky; a write-back was dropped
- o_Count  out  log2(DEPTH)+1  current FIFO occupancy

Function
REQ-005 The FSM SHALL have four states: IDLE, COLLECT, DRAIN, DONE.
REQ-006 IDLE -> COLLECT on i_Start: latch i_Base_Addr into the address counter; clear o_Overflow; empty the FIFO.
REQ-007 In COLLECT, i_Start SHALL be ignored, and i_Valid_WB_In SHALL push i_Data_WB_In into the FIFO.
REQ-008 COLLECT -> DRAIN on i_Flag_Finish_In; a push strobed in the same cycle SHALL still be accepted.
REQ-009 DRAIN -> DONE when the FIFO is empty and no beat is pending; pushes in DRAIN SHALL also be accepted.
REQ-010 DONE SHALL assert o_Done for exactly one cycle, then go to IDLE.
REQ-011 In IDLE and DONE, i_Valid_WB_In SHALL be ignored, with no push and no overflow.
REQ-012 o_Mem_Valid SHALL be 1 iff the state is COLLECT or DRAIN and the FIFO is non-empty.
REQ-013 o_Mem_Data SHALL be the FIFO head; o_Mem_Addr SHALL be the address counter.
REQ-014 A beat transfers when o_Mem_Valid && i_Mem_Ready; that cycle the FIFO pops and the address counter increments by 1, wrapping modulo 2^BIT_ADDR.
REQ-015 While o_Mem_Valid=1 and i_Mem_Ready=0, o_Mem_Data and o_Mem_Addr SHALL hold stable.
REQ-016 Minimum latency SHALL be 1 cycle: data pushed in cycle N appears on o_Mem_Data in cycle N+1.
REQ-017 Push and pop in the same cycle SHALL leave o_Count unchanged, including when full.
REQ-018 If full and a push arrives with no pop that cycle, the datum SHALL be dropped and o_Overflow set until the next i_Start.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; o_Count SHALL range 0..DEPTH.

Reset
REQ-020 Asserting RSTb low at any time SHALL force:
- state IDLE
- pointers and o_Count to 0
- o_Mem_Valid, o_Done and o_Overflow to 0
- o_Mem_Addr and o_Mem_Data to 0
REQ-021 An in-flight job interrupted by reset SHALL be abandoned; no beat SHALL issue after reset until the next i_Start plus a push.
REQ-022 FIFO storage contents SHALL NOT require reset.

Structure
REQ-023 `BIT_PSUM SHALL come from the shared parameter file; state encodings SHALL be defined there as `WBC_IDLE, `WBC_COLLECT, `WBC_DRAIN and `WBC_DONE.
REQ-024 The FIFO SHALL be one sub-module, sa_wb_fifo (push, pop, head, count, full, empty); the FSM and address counter SHALL live in sa_wb_collector.

Verification
REQ-025 Start base=0x0100, 4 pushes (1,2,3,4) with i_Mem_Ready=1, then finish -> writes (0x0100,1)..(0x0103,4) in order; o_Done pulses once; o_Overflow=0.
REQ-026 i_Mem_Ready=0 for 20 cycles while 17 pushes arrive with DEPTH=16 -> o_Count=16, o_Overflow=1, and the first 16 values are written after ready rises.
REQ-027 FIFO full with simultaneous push and pop -> o_Count stays 16, no overflow, and the pushed value is written last.
REQ-028 Base=0xFFFE, 3 pushes -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-029 RSTb low mid-DRAIN with 5 entries queued -> next cycle o_Mem_Valid=0 and o_Count=0; no o_Done until a new job.
REQ-030 Final push in the same cycle as i_Flag_Finish_In -> that datum is written before o_Done.

Source files
------------

// File: rtl/sa_wb_collector_pkg.sv
// Shared parameters for the systolic-array write-back collector:
// psum data width, FSM state encodings and the state enum built from them.
`ifndef SA_WB_COLLECTOR_PARAMS
`define SA_WB_COLLECTOR_PARAMS
`define BIT_PSUM    32
`define WBC_IDLE    2'd0
`define WBC_COLLECT 2'd1
`define WBC_DRAIN   2'd2
`define WBC_DONE    2'd3
`endif

package sa_wb_collector_pkg;

  // Width of one partial-sum word travelling from the core to memory.
  localparam int unsigned PSUM_W = `BIT_PSUM;

  // Collector job phases; encodings are shared with other blocks.
  typedef enum logic [1:0] {
    WBC_ST_IDLE    = `WBC_IDLE,
    WBC_ST_COLLECT = `WBC_COLLECT,
    WBC_ST_DRAIN   = `WBC_DRAIN,
    WBC_ST_DONE    = `WBC_DONE
  } wbc_state_e;

  // A memory beat moves only when a request is offered and accepted.
  function automatic logic wbc_beat(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/sa_wb_fifo.sv
// Circular FIFO buffering psum write-backs between the core and memory.
// A push into a full FIFO is only taken when a pop frees a slot that cycle.
module sa_wb_fifo
  import sa_wb_collector_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = PSUM_W
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Decide which operations happen this cycle and the resulting pointers/occupancy.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && !clear_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/sa_wb_collector.sv
// Collects psum write-backs from the systolic core into a FIFO and streams
// them to consecutive memory word addresses starting at a per-job base.
module sa_wb_collector
  import sa_wb_collector_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int BIT_ADDR = 16
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     i_Start,
  input  logic [BIT_ADDR-1:0]      i_Base_Addr,
  input  logic                     i_Valid_WB_In,
  input  logic [PSUM_W-1:0]        i_Data_WB_In,
  input  logic                     i_Flag_Finish_In,
  output logic                     o_Mem_Valid,
  output logic [BIT_ADDR-1:0]      o_Mem_Addr,
  output logic [PSUM_W-1:0]        o_Mem_Data,
  input  logic                     i_Mem_Ready,
  output logic                     o_Done,
  output logic                     o_Overflow,
  output logic [$clog2(DEPTH):0]   o_Count
);

  wbc_state_e          state_q, state_d;
  logic [BIT_ADDR-1:0] addr_q, addr_d;
  logic                ovf_q, ovf_d;

  logic                fifo_clear;
  logic                fifo_push;
  logic                fifo_pop;
  logic [PSUM_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  sa_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PSUM_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTb),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .data_i  (i_Data_WB_In),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state, address counter, sticky overflow and all outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ovf_d       = ovf_q;
    fifo_clear  = 1'b0;
    fifo_push   = 1'b0;
    o_Mem_Valid = ((state_q == WBC_ST_COLLECT) || (state_q == WBC_ST_DRAIN)) && !fifo_empty;
    fifo_pop    = wbc_beat(o_Mem_Valid, i_Mem_Ready);
    o_Mem_Addr  = addr_q;
    o_Mem_Data  = fifo_empty ? '0 : fifo_head;
    o_Done      = (state_q == WBC_ST_DONE);
    o_Overflow  = ovf_q;
    o_Count     = fifo_count;

    if (fifo_pop) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      WBC_ST_IDLE: begin
        if (i_Start) begin
          state_d    = WBC_ST_COLLECT;
          addr_d     = i_Base_Addr;
          ovf_d      = 1'b0;
          fifo_clear = 1'b1;
        end
      end
      WBC_ST_COLLECT: begin
        fifo_push = i_Valid_WB_In;
        if (i_Flag_Finish_In) begin
          state_d = WBC_ST_DRAIN;
        end
      end
      WBC_ST_DRAIN: begin
        fifo_push = i_Valid_WB_In;
        // A push arriving while empty still has to be written, so wait for it.
        if (fifo_empty && !i_Valid_WB_In) begin
          state_d = WBC_ST_DONE;
        end
      end
      WBC_ST_DONE: begin
        state_d = WBC_ST_IDLE;
      end
      default: begin
        state_d = WBC_ST_IDLE;
      end
    endcase

    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Job state, destination address counter and overflow flag registers.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= WBC_ST_IDLE;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
